cordic_engine_v2: RTL and testbench

Iterative, bit-serial-in-time CORDIC core that runs one micro-rotation per clock. It supports rotation mode (drive z→0) and vectoring mode (drive y→0), selected per transaction. It has an internal arctangent table, valid/ready handshakes on both sides, guard-bit datapath and saturated outputs. It replaces the v1 engine in the trig/magnitude pipeline; the upstream quadrant-fold stage feeds it, and the quadrant-unfold stage consumes it.

---
 rtl/cordic_pkg.sv | 51 +++++
 rtl/cordic_iter_stage.sv | 53 +++++
 rtl/cordic_engine_v2.sv | 178 +++++++++++++++++
 tb/tb_cordic_engine_v2.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the iterative CORDIC engine and its micro-rotation
// stage: mode encoding, FSM state encoding, arctangent table entries, the
// CORDIC gain-compensation constant and a generic saturation helper.
//
// Build option: CORDIC_GAIN_COMP_EN adds the GAIN state to the FSM encoding.
// -----------------------------------------------------------------------------
package cordic_pkg;

  localparam logic MODE_ROT = 1'b0;  // drive z towards 0
  localparam logic MODE_VEC = 1'b1;  // drive y towards 0

  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
`ifdef CORDIC_GAIN_COMP_EN
    ,
    ST_GAIN = 2'd3
`endif
  } state_t;

  // round(atan(2^-i) * 2^(width-1) / pi); only ever evaluated with constant
  // arguments, so it folds to a fixed table at elaboration.
  function automatic int atan_lut(input int i, input int width);
    real r;
    r = $atan(1.0 / (2.0 ** i)) * (2.0 ** (width - 1)) / PI;
    return $rtoi(r + 0.5);
  endfunction

  // round(1/An * 2^(width-1)), An being the asymptotic CORDIC gain.
  function automatic int gain_k(input int width);
    return $rtoi(0.6072529350 * (2.0 ** (width - 1)) + 0.5);
  endfunction

  // Clamp a signed value to the two's-complement range of 'width' bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/cordic_iter_stage.sv
// -----------------------------------------------------------------------------
// cordic_iter_stage
// Combinational single CORDIC micro-rotation. Holds its own constant
// arctangent table indexed by the iteration number.
//
// Ports:
//   x, y     in   XW          signed working x/y (with guard bits)
//   z        in   DATA_WIDTH  signed angle accumulator
//   iter     in   CNT_W       iteration index i (shift amount, table index)
//   mode     in   1           MODE_ROT / MODE_VEC
//   x_next   out  XW          x - d*(y >>> i)
//   y_next   out  XW          y + d*(x >>> i)
//   z_next   out  DATA_WIDTH  z - d*atan[i]
// -----------------------------------------------------------------------------
module cordic_iter_stage
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int XW         = 20,
  parameter int CNT_W      = 4
) (
  input  logic signed [XW-1:0]         x,
  input  logic signed [XW-1:0]         y,
  input  logic signed [DATA_WIDTH-1:0] z,
  input  logic        [CNT_W-1:0]      iter,
  input  logic                         mode,
  output logic signed [XW-1:0]         x_next,
  output logic signed [XW-1:0]         y_next,
  output logic signed [DATA_WIDTH-1:0] z_next
);

  logic signed [DATA_WIDTH-1:0] atan_tab [2**CNT_W];
  logic signed [DATA_WIDTH-1:0] atan_i;
  logic signed [XW-1:0]         x_sh;
  logic signed [XW-1:0]         y_sh;
  logic                         d_pos;

  for (genvar g = 0; g < 2**CNT_W; g++) begin : g_atan
    assign atan_tab[g] = DATA_WIDTH'(atan_lut(g, DATA_WIDTH));
  end

  assign atan_i = atan_tab[iter];
  assign x_sh   = x >>> iter;
  assign y_sh   = y >>> iter;

  // d = +1 when rotating towards z = 0 from z >= 0, or towards y = 0 from y < 0
  assign d_pos = (mode == MODE_ROT) ? ~z[DATA_WIDTH-1] : y[XW-1];

  assign x_next = d_pos ? (x - y_sh)     : (x + y_sh);
  assign y_next = d_pos ? (y + x_sh)     : (y - x_sh);
  assign z_next = d_pos ? (z - atan_i)   : (z + atan_i);

endmodule

// File: rtl/cordic_engine_v2.sv
// -----------------------------------------------------------------------------
// cordic_engine_v2
// Iterative CORDIC core, one micro-rotation per clock, rotation or vectoring
// mode per transaction, valid/ready on both sides, saturated x/y outputs.
//
// Build option: CORDIC_GAIN_COMP_EN inserts a one-clock GAIN state that scales
// x/y by 1/An before saturation (latency N_ITER+1 instead of N_ITER).
//
// Ports:
//   i_clk, i_rst        clock (rising edge), async active-high reset
//   i_valid / o_ready   input handshake; o_ready high only in IDLE
//   i_mode              0 = rotation, 1 = vectoring
//   i_x, i_y, i_z       signed operands, angle scale +-2^(DATA_WIDTH-1) = +-pi
//   i_quadrant          sideband, returned on o_quadrant
//   o_valid / i_ready   output handshake; result held until accepted
//   o_x, o_y, o_z       results (x/y saturated)
//   o_quadrant          quadrant captured at accept
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | o_ready=1, waiting for i_valid
// RUN     | one micro-rotation per clock, count = 0..N_ITER-1
// GAIN    | (option) x/y scaled by K, results registered
// DONE    | o_valid=1, outputs frozen until i_ready
// -----------------------------------------------------------------------------
module cordic_engine_v2
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int N_ITER     = 16,
  parameter int GUARD_BITS = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_mode,
  input  logic signed [DATA_WIDTH-1:0] i_x,
  input  logic signed [DATA_WIDTH-1:0] i_y,
  input  logic signed [DATA_WIDTH-1:0] i_z,
  input  logic        [1:0]            i_quadrant,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic signed [DATA_WIDTH-1:0] o_x,
  output logic signed [DATA_WIDTH-1:0] o_y,
  output logic signed [DATA_WIDTH-1:0] o_z,
  output logic        [1:0]            o_quadrant
);

  localparam int XW    = DATA_WIDTH + GUARD_BITS;
  localparam int CNT_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  state_t                       state;
  logic        [CNT_W-1:0]      count;
  logic signed [XW-1:0]         x_r;
  logic signed [XW-1:0]         y_r;
  logic signed [DATA_WIDTH-1:0] z_r;
  logic                         mode_r;
  logic        [1:0]            quad_r;

  logic signed [XW-1:0]         x_nx;
  logic signed [XW-1:0]         y_nx;
  logic signed [DATA_WIDTH-1:0] z_nx;
  logic                         last_iter;

  cordic_iter_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .XW         (XW),
    .CNT_W      (CNT_W)
  ) u_iter (
    .x      (x_r),
    .y      (y_r),
    .z      (z_r),
    .iter   (count),
    .mode   (mode_r),
    .x_next (x_nx),
    .y_next (y_nx),
    .z_next (z_nx)
  );

  assign last_iter = (count == CNT_W'(N_ITER - 1));

`ifdef CORDIC_GAIN_COMP_EN
  // Extra product bit keeps K positive as a signed operand.
  localparam int PW = XW + DATA_WIDTH + 1;
  localparam logic signed [DATA_WIDTH:0] K_GAIN = (DATA_WIDTH+1)'(gain_k(DATA_WIDTH));
  localparam logic signed [PW-1:0]       RND    = PW'(1) <<< (DATA_WIDTH - 2);

  logic signed [PW-1:0] x_prod;
  logic signed [PW-1:0] y_prod;
  logic signed [PW-1:0] x_scl;
  logic signed [PW-1:0] y_scl;

  assign x_prod = PW'(x_r) * PW'(K_GAIN);
  assign y_prod = PW'(y_r) * PW'(K_GAIN);
  // round half-up, then drop the K fraction bits
  assign x_scl  = (x_prod + RND) >>> (DATA_WIDTH - 1);
  assign y_scl  = (y_prod + RND) >>> (DATA_WIDTH - 1);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      x_r        <= '0;
      y_r        <= '0;
      z_r        <= '0;
      mode_r     <= 1'b0;
      quad_r     <= 2'd0;
      o_ready    <= 1'b1;
      o_valid    <= 1'b0;
      o_x        <= '0;
      o_y        <= '0;
      o_z        <= '0;
      o_quadrant <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            x_r     <= XW'(i_x);
            y_r     <= XW'(i_y);
            z_r     <= i_z;
            mode_r  <= i_mode;
            quad_r  <= i_quadrant;
            count   <= '0;
            o_ready <= 1'b0;
            state   <= ST_RUN;
          end
        end

        ST_RUN: begin
          x_r   <= x_nx;
          y_r   <= y_nx;
          z_r   <= z_nx;
          count <= count + 1'b1;
          if (last_iter) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= ST_GAIN;
`else
            o_x        <= DATA_WIDTH'(saturate(64'(x_nx), DATA_WIDTH));
            o_y        <= DATA_WIDTH'(saturate(64'(y_nx), DATA_WIDTH));
            o_z        <= z_nx;
            o_quadrant <= quad_r;
            o_valid    <= 1'b1;
            state      <= ST_DONE;
`endif
          end
        end

`ifdef CORDIC_GAIN_COMP_EN
        ST_GAIN: begin
          o_x        <= DATA_WIDTH'(saturate(64'(x_scl), DATA_WIDTH));
          o_y        <= DATA_WIDTH'(saturate(64'(y_scl), DATA_WIDTH));
          o_z        <= z_r;
          o_quadrant <= quad_r;
          o_valid    <= 1'b1;
          state      <= ST_DONE;
        end
`endif

        ST_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= ST_IDLE;
          end
        end

        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_engine_v2.sv
// -----------------------------------------------------------------------------
// tb_cordic_engine_v2
// Randomised and directed transactions checked against a real-arithmetic
// model of ideal rotation / vectoring scaled by the CORDIC gain.
// Honours CORDIC_GAIN_COMP_EN for expected gain and latency.
// -----------------------------------------------------------------------------
module tb_cordic_engine_v2;

  localparam int  DW    = 18;
  localparam int  NI    = 16;
  localparam int  MAXV  = 131071;
  localparam int  MINV  = -131072;
  localparam real SCALE = 131072.0;
  localparam real M_PI  = 3.14159265358979323846;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  EXP_LAT = NI + 1;
`else
  localparam int  EXP_LAT = NI;
`endif

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b0;
  logic                 i_valid = 1'b0;
  logic                 i_mode = 1'b0;
  logic                 i_ready = 1'b0;
  logic signed [DW-1:0] i_x = '0;
  logic signed [DW-1:0] i_y = '0;
  logic signed [DW-1:0] i_z = '0;
  logic        [1:0]    i_quadrant = 2'd0;
  logic                 o_ready;
  logic                 o_valid;
  logic signed [DW-1:0] o_x;
  logic signed [DW-1:0] o_y;
  logic signed [DW-1:0] o_z;
  logic        [1:0]    o_quadrant;

  cordic_engine_v2 #(
    .DATA_WIDTH (DW),
    .N_ITER     (NI),
    .GUARD_BITS (2)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_mode     (i_mode),
    .i_x        (i_x),
    .i_y        (i_y),
    .i_z        (i_z),
    .i_quadrant (i_quadrant),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_x        (o_x),
    .o_y        (o_y),
    .o_z        (o_z),
    .o_quadrant (o_quadrant)
  );

  always #5 i_clk = ~i_clk;

  int  n_vec = 0;
  int  n_err = 0;
  real gain_eff;

  task automatic check_val(input string tag, input int obs, input int exp, input int tol);
    int diff;
    n_vec++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int round_clamp(input real v);
    real c;
    c = v;
    if (c > MAXV) c = MAXV;
    if (c < MINV) c = MINV;
    return (c >= 0.0) ? $rtoi(c + 0.5) : $rtoi(c - 0.5);
  endfunction

  // Ideal result: rotation by z, or magnitude/angle of (x,y), times the gain.
  task automatic model(input logic mode, input int x, input int y, input int z,
                       output int ex, output int ey, output int ez);
    real a;
    real rx;
    real ry;
    real zr;
    if (!mode) begin
      a  = real'(z) * M_PI / SCALE;
      rx = gain_eff * (real'(x) * $cos(a) - real'(y) * $sin(a));
      ry = gain_eff * (real'(x) * $sin(a) + real'(y) * $cos(a));
      ex = round_clamp(rx);
      ey = round_clamp(ry);
      ez = 0;
    end else begin
      rx = gain_eff * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      zr = real'(z) + $atan2(real'(y), real'(x)) * SCALE / M_PI;
      ex = round_clamp(rx);
      ey = 0;
      ez = (zr >= 0.0) ? $rtoi(zr + 0.5) : $rtoi(zr - 0.5);
    end
  endtask

  task automatic check_outputs(input int ex, input int ey, input int ez, input logic [1:0] quad,
                               input int txy, input int tz);
    check_val("o_x", int'(o_x), ex, (ex == MAXV || ex == MINV) ? 0 : txy);
    check_val("o_y", int'(o_y), ey, (ey == MAXV || ey == MINV) ? 0 : txy);
    check_val("o_z", int'(o_z), ez, tz);
    check_val("o_quadrant", int'(o_quadrant), int'(quad), 0);
  endtask

  // One full transaction: accept, latency, result, optional backpressure with
  // ignored i_valid pulses, then release.
  task automatic do_txn(input logic mode, input int x, input int y, input int z,
                        input logic [1:0] quad, input int bp, input bit junk,
                        input int txy, input int tz);
    int ex, ey, ez, w, lat;
    model(mode, x, y, z, ex, ey, ez);
    @(negedge i_clk);
    w = 0;
    while (!o_ready && w < 200) begin
      @(negedge i_clk);
      w++;
    end
    if (!o_ready) begin
      check_val("ready_timeout", int'(o_ready), 1, 0);
      return;
    end
    i_valid    = 1'b1;
    i_mode     = mode;
    i_x        = x[DW-1:0];
    i_y        = y[DW-1:0];
    i_z        = z[DW-1:0];
    i_quadrant = quad;
    @(posedge i_clk);
    #1;
    i_valid    = 1'b0;
    i_mode     = ~mode;
    i_x        = DW'($urandom);
    i_y        = DW'($urandom);
    i_z        = DW'($urandom);
    i_quadrant = ~quad;
    check_val("ready_in_run", int'(o_ready), 0, 0);
    lat = 0;
    do begin
      @(posedge i_clk);
      #1;
      lat++;
    end while (!o_valid && lat < 100);
    check_val("latency", lat, EXP_LAT, 0);
    if (!o_valid) return;
    check_outputs(ex, ey, ez, quad, txy, tz);
    for (int c = 0; c < bp; c++) begin
      @(negedge i_clk);
      if (junk) begin
        i_valid = 1'b1;
        i_x     = DW'($urandom);
        i_y     = DW'($urandom);
        i_z     = DW'($urandom);
      end
      check_val("hold_valid", int'(o_valid), 1, 0);
      check_val("hold_ready", int'(o_ready), 0, 0);
      check_outputs(ex, ey, ez, quad, txy, tz);
    end
    @(negedge i_clk);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    i_valid = 1'b0;
    check_val("valid_drop", int'(o_valid), 0, 0);
    check_val("ready_back", int'(o_ready), 1, 0);
  endtask

  initial begin
    real g;
    int  k;
    g = 1.0;
    for (int i = 0; i < NI; i++) g = g * $sqrt(1.0 + 2.0 ** (-2 * i));
`ifdef CORDIC_GAIN_COMP_EN
    k = $rtoi(0.6072529350 * SCALE + 0.5);
    g = g * real'(k) / SCALE;
`else
    k = 0;
`endif
    gain_eff = g;

    // reset state
    #2 i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #2;
    check_val("rst_valid", int'(o_valid), 0, 0);
    check_val("rst_x", int'(o_x), 0, 0);
    check_val("rst_y", int'(o_y), 0, 0);
    check_val("rst_z", int'(o_z), 0, 0);
    check_val("rst_quad", int'(o_quadrant), 0, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check_val("rst_ready", int'(o_ready), 1, 0);

    // directed cases
    do_txn(1'b0, 40000, 0, 32768, 2'd2, 0, 1'b0, 8, 4);
    do_txn(1'b1, 30000, 30000, 0, 2'd1, 5, 1'b1, 8, 4);
    do_txn(1'b1, 131071, 131071, 0, 2'd3, 1, 1'b0, 24, 4);
    do_txn(1'b0, -100000, -100000, 0, 2'd1, 2, 1'b1, 16, 6);

    // async reset in the middle of RUN (count = 7)
    @(negedge i_clk);
    i_valid = 1'b1;
    i_mode  = 1'b0;
    i_x     = 18'sd20000;
    i_y     = 18'sd10000;
    i_z     = 18'sd10000;
    i_quadrant = 2'd3;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    repeat (7) @(posedge i_clk);
    #3 i_rst = 1'b1;
    #1;
    check_val("abort_valid", int'(o_valid), 0, 0);
    check_val("abort_ready", int'(o_ready), 1, 0);
    check_val("abort_x", int'(o_x), 0, 0);
    check_val("abort_quad", int'(o_quadrant), 0, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check_val("post_rst_ready", int'(o_ready), 1, 0);
    do_txn(1'b0, 20000, 10000, 10000, 2'd2, 0, 1'b0, 16, 6);

    // randomised transactions
    for (int t = 0; t < 30; t++) begin
      int x, y, z, bp;
      logic m;
      logic [1:0] q;
      m  = 1'($urandom);
      q  = 2'($urandom);
      bp = int'($urandom_range(0, 3));
      if (!m) begin
        x = int'($urandom_range(0, 60000)) - 30000;
        y = int'($urandom_range(0, 60000)) - 30000;
        z = int'($urandom_range(0, 120000)) - 60000;
      end else begin
        x = int'($urandom_range(1000, 40000));
        y = int'($urandom_range(0, 80000)) - 40000;
        z = int'($urandom_range(0, 40000)) - 20000;
      end
      do_txn(m, x, y, z, q, bp, 1'($urandom), 16, 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
